uart_program_loader: RTL and testbench

Parametrised UART program loader that receives a framed program image over the board serial line and writes it, word by word, into instruction memory. It sits between `UART_TXD_IN` and the instruction memory write port, ahead of PC control. It replaces the fixed 16-bit, fixed-depth load path with configurable word width, depth and baud divisor. It adds length framing, checksum verification and error reporting. PC control holds the pipeline until `load_done` rises.

---
 rtl/uart_program_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_program_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - UART framed program image receiver writing words into instruction memory
// Frame: length byte N, N big-endian words, 8-bit additive checksum over the data bytes.
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int INSTR_WIDTH  = 16,
    parameter int DEPTH        = 256,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   UART_TXD_IN,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   load_done,
    output logic                   load_error
);
    localparam int BYTES = INSTR_WIDTH / 8;
    localparam int CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int AW    = (BYTES > 1) ? INSTR_WIDTH - 8 : 8;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]    BYTE_LAST = 8'(BYTES - 1);
    localparam logic [8:0]    DEPTH_W   = 9'(DEPTH);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {L_WAIT_LEN, L_RECV_DATA, L_RECV_SUM, L_DONE, L_ERROR} ld_state_t;

    rx_state_t        rx_state;
    logic             sync1, sync2, line_prev;
    logic [CW-1:0]    rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             byte_valid, frame_err;

    ld_state_t        ld_state;
    logic [7:0]       len, sum, byte_idx;
    logic [8:0]       word_cnt;
    logic [AW-1:0]    asm_word;
    logic [INSTR_WIDTH-1:0] asm_next;

    // asm_word holds the bytes of the current word received so far; the new byte lands in the LSBs
    generate
        if (BYTES > 1) begin : g_multi
            assign asm_next = {asm_word, rx_shift};
        end else begin : g_single
            assign asm_next = rx_shift;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            line_prev  <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= UART_TXD_IN;
            sync2      <= sync1;
            line_prev  <= sync2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (line_prev && !sync2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {sync2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == BIT_LAST) begin
                        rx_cnt     <= '0;
                        rx_state   <= RX_IDLE;
                        byte_valid <= sync2;
                        frame_err  <= !sync2;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ld_state   <= L_WAIT_LEN;
            len        <= '0;
            sum        <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            asm_word   <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (frame_err && ld_state != L_ERROR) begin
                ld_state   <= L_ERROR;
                load_error <= 1'b1;
                load_done  <= 1'b0;
                busy       <= 1'b0;
            end else if (byte_valid) begin
                case (ld_state)
                    L_WAIT_LEN, L_DONE: begin
                        load_done <= 1'b0;
                        len       <= rx_shift;
                        sum       <= '0;
                        byte_idx  <= '0;
                        word_cnt  <= '0;
                        if (rx_shift == 8'd0) begin
                            ld_state <= L_RECV_SUM;
                            busy     <= 1'b1;
                        end else if ({1'b0, rx_shift} > DEPTH_W) begin
                            ld_state   <= L_ERROR;
                            load_error <= 1'b1;
                        end else begin
                            ld_state <= L_RECV_DATA;
                            busy     <= 1'b1;
                        end
                    end
                    L_RECV_DATA: begin
                        sum      <= sum + rx_shift;
                        asm_word <= asm_next[AW-1:0];
                        if (byte_idx == BYTE_LAST) begin
                            byte_idx <= '0;
                            wr_en    <= 1'b1;
                            wr_addr  <= ADDR_WIDTH'(word_cnt);
                            wr_data  <= asm_next;
                            word_cnt <= word_cnt + 9'd1;
                            if (word_cnt + 9'd1 == {1'b0, len}) ld_state <= L_RECV_SUM;
                        end else begin
                            byte_idx <= byte_idx + 8'd1;
                        end
                    end
                    L_RECV_SUM: begin
                        busy <= 1'b0;
                        if (rx_shift == sum) begin
                            ld_state  <= L_DONE;
                            load_done <= 1'b1;
                        end else begin
                            ld_state   <= L_ERROR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - scoreboard bench for uart_program_loader
// Instance 0: 16-bit words, depth 4. Instance 1: 24-bit words, depth 8. Both CLKS_PER_BIT = 4.
module tb_uart_program_loader;
    localparam int CPB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst  = 2'b11;
    logic [1:0]  line = 2'b11;
    logic        we0, busy0, done0, err0;
    logic [1:0]  addr0;
    logic [15:0] data0;
    logic        we1, busy1, done1, err1;
    logic [2:0]  addr1;
    logic [23:0] data1;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .INSTR_WIDTH(16), .DEPTH(4), .ADDR_WIDTH(2)) u16 (
        .CLK(clk), .RST(rst[0]), .UART_TXD_IN(line[0]), .wr_en(we0), .wr_addr(addr0),
        .wr_data(data0), .busy(busy0), .load_done(done0), .load_error(err0));
    uart_program_loader #(.CLKS_PER_BIT(CPB), .INSTR_WIDTH(24), .DEPTH(8), .ADDR_WIDTH(3)) u24 (
        .CLK(clk), .RST(rst[1]), .UART_TXD_IN(line[1]), .wr_en(we1), .wr_addr(addr1),
        .wr_data(data1), .busy(busy1), .load_done(done1), .load_error(err1));

    typedef struct {int inst; int kind; logic [31:0] addr; logic [31:0] data;} ev_t;
    ev_t        exp_q[$];
    logic [7:0] frame_data[$];
    int         tests = 0;
    int         fails = 0;
    bit         model_err[2];
    bit         model_done[2];
    logic [1:0] prev_done = 2'b00;
    logic [1:0] prev_err  = 2'b00;

    // Kinds: 0 = write, 1 = load_done rise, 2 = load_error rise
    task automatic mon_event(int k, int kind, logic [31:0] a, logic [31:0] d);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: inst=%0d kind=%0d addr=%0h data=%0h, expected no event", k, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.inst != k || e.kind != kind || (kind == 0 && (e.addr != a || e.data != d))) begin
                fails++;
                $display("FAIL event: got inst=%0d kind=%0d addr=%0h data=%0h, expected inst=%0d kind=%0d addr=%0h data=%0h",
                         k, kind, a, d, e.inst, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (we0) mon_event(0, 0, 32'(addr0), 32'(data0));
        if (done0 && !prev_done[0]) mon_event(0, 1, 0, 0);
        if (err0 && !prev_err[0]) mon_event(0, 2, 0, 0);
        if (we1) mon_event(1, 0, 32'(addr1), 32'(data1));
        if (done1 && !prev_done[1]) mon_event(1, 1, 0, 0);
        if (err1 && !prev_err[1]) mon_event(1, 2, 0, 0);
        prev_done <= {done1, done0};
        prev_err  <= {err1, err0};
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(string name, int k, bit b, bit dn, bit er);
        check({name, "_busy"}, 32'(k == 0 ? busy0 : busy1), 32'(b));
        check({name, "_done"}, 32'(k == 0 ? done0 : done1), 32'(dn));
        check({name, "_error"}, 32'(k == 0 ? err0 : err1), 32'(er));
    endtask

    task automatic push_ev(int k, int kind, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e.inst = k; e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(int k);
        rst[k]  = 1'b1;
        line[k] = 1'b1;
        repeat (3) @(posedge clk);
        rst[k] = 1'b0;
        model_err[k]  = 1'b0;
        model_done[k] = 1'b0;
        @(negedge clk);
        check("reset_wr_en", 32'(k == 0 ? we0 : we1), 0);
        check("reset_wr_addr", k == 0 ? 32'(addr0) : 32'(addr1), 0);
        check("reset_wr_data", k == 0 ? 32'(data0) : 32'(data1), 0);
        check_status("reset", k, 0, 0, 0);
    endtask

    task automatic send_bit(int k, logic v);
        line[k] = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic send_byte(int k, logic [7:0] b, bit stop_ok);
        send_bit(k, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(k, b[i]);
        send_bit(k, stop_ok);
        if (!stop_ok) send_bit(k, 1'b1);
    endtask

    // Frame-level reference: decide writes and final status from N, data, checksum and framing fault position
    task automatic run_frame(int k, int n, logic [7:0] csum, int ferr_at);
        int bpw, depth, nb, full;
        bit prior_err, len_ok;
        logic [7:0]  s;
        logic [31:0] w;
        logic [7:0]  fr[$];
        bpw = (k == 0) ? 2 : 3;
        depth = (k == 0) ? 4 : 8;
        nb = n * bpw;
        prior_err = model_err[k];
        len_ok = (ferr_at != 0) && (n <= depth);
        if (!prior_err) begin
            model_done[k] = 1'b0;
            if (!len_ok) begin
                push_ev(k, 2, 0, 0);
                model_err[k] = 1'b1;
            end else begin
                full = (ferr_at > 0 && ferr_at <= nb) ? (ferr_at - 1) / bpw : n;
                for (int wi = 0; wi < full; wi++) begin
                    w = 0;
                    for (int j = 0; j < bpw; j++) w = (w << 8) | 32'(frame_data[wi * bpw + j]);
                    push_ev(k, 0, 32'(wi), w);
                end
                s = 8'd0;
                for (int i = 0; i < nb; i++) s = s + frame_data[i];
                if ((ferr_at > 0 && ferr_at <= nb + 1) || csum != s) begin
                    push_ev(k, 2, 0, 0);
                    model_err[k] = 1'b1;
                end else begin
                    push_ev(k, 1, 0, 0);
                    model_done[k] = 1'b1;
                end
            end
        end
        fr.push_back(8'(n));
        for (int i = 0; i < nb; i++) fr.push_back(frame_data[i]);
        fr.push_back(csum);
        for (int i = 0; i < fr.size(); i++) begin
            send_byte(k, fr[i], i != ferr_at);
            if (i == 0) begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check_status("after_len", k, !prior_err && len_ok, 0, prior_err || !len_ok);
            end
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_status("frame_end", k, 0, model_done[k], model_err[k]);
    endtask

    function automatic logic [7:0] good_sum();
        logic [7:0] s = 8'd0;
        foreach (frame_data[i]) s = s + frame_data[i];
        return s;
    endfunction

    task automatic rand_data(int nbytes);
        frame_data.delete();
        for (int i = 0; i < nbytes; i++) frame_data.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        int n, r, fe;
        logic [7:0] cs;
        do_reset(0);
        do_reset(1);

        // Nominal frame, then a one-cycle glitch on the idle line
        frame_data = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(0, 2, good_sum(), -1);
        line[0] = 1'b0;
        @(posedge clk);
        line[0] = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check_status("glitch", 0, 0, 1, 0);

        // Empty load, full-depth load
        frame_data.delete();
        run_frame(0, 0, 8'h00, -1);
        rand_data(8);
        run_frame(0, 4, good_sum(), -1);

        // Bad checksum, later frame ignored
        frame_data = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        run_frame(0, 2, 8'h6F, -1);
        run_frame(0, 2, good_sum(), -1);
        do_reset(0);

        // Oversize length
        rand_data(10);
        run_frame(0, 5, good_sum(), -1);
        do_reset(0);

        // Stop bit low on the second data byte
        rand_data(4);
        run_frame(0, 2, good_sum(), 2);
        do_reset(0);

        // Reset after the first byte of a word and mid-byte
        send_byte(0, 8'h02, 1'b1);
        send_byte(0, 8'h12, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_status("midload", 0, 1, 0, 0);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        do_reset(0);
        frame_data = '{8'h5A, 8'hC3, 8'h01, 8'hFE};
        run_frame(0, 2, good_sum(), -1);

        // Randomized frames
        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(0, 5);
            rand_data(n * 2);
            r = $urandom_range(0, 9);
            cs = (r == 0) ? good_sum() ^ 8'h5A : good_sum();
            fe = (r == 1) ? $urandom_range(0, n * 2 + 1) : -1;
            run_frame(0, n, cs, fe);
            if (model_err[0]) do_reset(0);
        end

        // 24-bit words: reload after done
        frame_data = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(1, 1, good_sum(), -1);
        rand_data(6);
        run_frame(1, 2, good_sum(), -1);
        rand_data(24);
        run_frame(1, 8, good_sum(), -1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("events_outstanding", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
